// File: rtl/ir_frame_decoder_if.sv
// Command handshake between the IR frame decoder (master) and the cart control block (slave).
interface ir_frame_decoder_if;
  logic [31:0] command;
  logic        ready;
  logic        ack;

  modport master (output command, output ready, input ack);
  modport slave  (input command, input ready, output ack);
endinterface

// File: rtl/ir_frame_decoder.sv
// Samsung 32-bit IR frame decoder with pulse-width windows, timeout and a ready/ack handoff.
// Optional IR_INVERT_CHECK_EN: commit only when the top byte is the inverse of the next byte.
module ir_frame_decoder #(
  parameter int clk_hz        = 25000000,
  parameter int tick_us       = 10,
  parameter int timeout_ticks = 600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_in,
  ir_frame_decoder_if.master cmd_if,
  output logic               frame_err,
  output logic               busy
);

  localparam int PRE_RAW = (clk_hz / 1000) * tick_us / 1000;
  localparam int PRE_DIV = (PRE_RAW < 1) ? 1 : PRE_RAW;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

  // Window limits are written for a 10 us tick and rescaled to the configured tick.
  function automatic logic [9:0] win(input int base);
    return 10'(base * 10 / tick_us);
  endfunction

  localparam logic [9:0] LEAD_MIN  = win(400);
  localparam logic [9:0] LEAD_MAX  = win(500);
  localparam logic [9:0] BIT_MIN   = win(30);
  localparam logic [9:0] BIT_MAX   = win(80);
  localparam logic [9:0] ONE_MIN   = win(140);
  localparam logic [9:0] ONE_MAX   = win(200);
  localparam logic [9:0] TIMEOUT_W = 10'(timeout_ticks);
  localparam logic [9:0] WIDTH_SAT = 10'h3FF;

  function automatic logic in_win(input logic [9:0] w, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_DONE       = 3'd6
  } state_e;

  logic             sync1_q, sync2_q, level_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [9:0]       width_q, width_d;
  state_e           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic [31:0]      command_q, command_d;
  logic             ready_q, ready_d;
  logic             ack_seen_q, ack_seen_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             tick_s, fall_s, rise_s, abort_s, check_ok_s;

  assign fall_s = level_q & ~sync2_q;
  assign rise_s = ~level_q & sync2_q;
  assign tick_s = (pre_q == PRE_LAST);

`ifdef IR_INVERT_CHECK_EN
  assign check_ok_s = (shift_q[31:24] == ~shift_q[23:16]);
`else
  assign check_ok_s = 1'b1;
`endif

  // Prescaler and edge-relative width measurement.
  always_comb begin
    pre_d   = pre_q;
    width_d = width_q;
    if (tick_s) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
    if (fall_s || rise_s) begin
      width_d = 10'd0;
    end else if (tick_s && (width_q != WIDTH_SAT)) begin
      width_d = width_q + 10'd1;
    end else begin
      width_d = width_q;
    end
  end

  // Frame state machine, bit capture and ready/ack handoff.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    command_d  = command_q;
    ready_d    = ready_q;
    ack_seen_d = ack_seen_q;
    abort_s    = 1'b0;

    if (ready_q && cmd_if.ack) begin
      ready_d    = 1'b0;
      ack_seen_d = 1'b1;
    end else begin
      ready_d    = ready_q;
    end

    if ((state_q != ST_IDLE) && (width_q > TIMEOUT_W)) begin
      abort_s = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fall_s) state_d = ST_LEAD_MARK;
          else        state_d = ST_IDLE;
        end
        ST_LEAD_MARK: begin
          if (rise_s && in_win(width_q, LEAD_MIN, LEAD_MAX)) begin
            state_d = ST_LEAD_SPACE;
          end else if (rise_s) begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LEAD_MARK;
          end
        end
        ST_LEAD_SPACE: begin
          if (fall_s && in_win(width_q, LEAD_MIN, LEAD_MAX)) begin
            state_d   = ST_BIT_MARK;
            bit_cnt_d = 5'd0;
          end else if (fall_s) begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LEAD_SPACE;
          end
        end
        ST_BIT_MARK: begin
          if (rise_s && in_win(width_q, BIT_MIN, BIT_MAX)) begin
            state_d = ST_BIT_SPACE;
          end else if (rise_s) begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BIT_MARK;
          end
        end
        ST_BIT_SPACE: begin
          if (fall_s && (in_win(width_q, BIT_MIN, BIT_MAX) || in_win(width_q, ONE_MIN, ONE_MAX))) begin
            shift_d[bit_cnt_q] = in_win(width_q, ONE_MIN, ONE_MAX);
            if (bit_cnt_q == 5'd31) begin
              state_d = ST_STOP_MARK;
            end else begin
              state_d   = ST_BIT_MARK;
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end else if (fall_s) begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BIT_SPACE;
          end
        end
        ST_STOP_MARK: begin
          if (rise_s && in_win(width_q, BIT_MIN, BIT_MAX)) begin
            state_d = ST_DONE;
          end else if (rise_s) begin
            abort_s = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STOP_MARK;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          // A held ack blocks the commit so control never pairs an old ack with new data.
          if (!check_ok_s) begin
            abort_s = 1'b1;
          end else if (!ready_q && !cmd_if.ack) begin
            command_d  = shift_q;
            ready_d    = 1'b1;
            ack_seen_d = 1'b0;
          end else begin
            command_d  = command_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    frame_err_d = abort_s;
    busy_d      = (state_d != ST_IDLE);
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      pre_q       <= '0;
      width_q     <= 10'd0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 32'd0;
      command_q   <= 32'd0;
      ready_q     <= 1'b0;
      ack_seen_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= ir_in;
      sync2_q     <= sync1_q;
      level_q     <= sync2_q;
      pre_q       <= pre_d;
      width_q     <= width_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      command_q   <= command_d;
      ready_q     <= ready_d;
      ack_seen_q  <= ack_seen_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_if.command = command_q;
  assign cmd_if.ready   = ready_q;
  assign frame_err      = frame_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Self-checking bench for ir_frame_decoder: 10 us clock so one clk equals one 10 us tick.
module tb_ir_frame_decoder;
  localparam int CLK_HZ  = 100000;
  localparam int TICK_US = 10;
  localparam int TIMEOUT = 600;

  logic clk = 1'b0;
  logic rst;
  logic ir_in;
  logic frame_err;
  logic busy;
  ir_frame_decoder_if bus();

  ir_frame_decoder #(.clk_hz(CLK_HZ), .tick_us(TICK_US), .timeout_ticks(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .cmd_if(bus), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_pulses = 0;
  int err_double = 0;
  int cmd_changed = 0;
  logic err_prev = 1'b0;
  logic ready_prev = 1'b0;
  logic [31:0] cmd_prev = 32'd0;

  logic        exp_ready;
  logic [31:0] exp_cmd;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes frame_err pulse widths and command stability while ready is held.
  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      err_pulses = err_pulses + 1;
      if (err_prev === 1'b1) err_double = err_double + 1;
    end
    if ((ready_prev === 1'b1) && (bus.ready === 1'b1) && (bus.command !== cmd_prev))
      cmd_changed = cmd_changed + 1;
    err_prev   = frame_err;
    ready_prev = bus.ready;
    cmd_prev   = bus.command;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  function automatic bit frame_ok(input logic [31:0] d);
`ifdef IR_INVERT_CHECK_EN
    return d[31:24] == ~d[23:16];
`else
    return 1'b1;
`endif
  endfunction

  // Reference outcome of one well-timed frame arriving while ack holds its present level.
  function automatic int model_frame(input logic [31:0] d);
    if (!frame_ok(d)) return 1;
    if (!exp_ready && !bus.ack) begin
      exp_ready = 1'b1;
      exp_cmd   = d;
    end
    return 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    ir_in = lvl;
    wait_cyc(n);
  endtask

  task automatic send_bits(input logic [31:0] d, input int nbits, input bit jit);
    hold(1'b0, jit ? int'($urandom_range(420, 480)) : 450);
    hold(1'b1, jit ? int'($urandom_range(420, 480)) : 450);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, jit ? int'($urandom_range(40, 70)) : 56);
      if (d[i]) hold(1'b1, jit ? int'($urandom_range(150, 190)) : 169);
      else      hold(1'b1, jit ? int'($urandom_range(40, 70)) : 56);
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input bit jit);
    send_bits(d, 32, jit);
    hold(1'b0, jit ? int'($urandom_range(40, 70)) : 56);
    ir_in = 1'b1;
  endtask

  task automatic check_outputs(input string name, input int err_base, input int err_exp);
    tests++;
    if (bus.ready !== exp_ready) begin
      fails++;
      $display("FAIL %s ready: got %b expected %b", name, bus.ready, exp_ready);
    end
    tests++;
    if (bus.command !== exp_cmd) begin
      fails++;
      $display("FAIL %s command: got %h expected %h", name, bus.command, exp_cmd);
    end
    tests++;
    if ((err_pulses - err_base) !== err_exp) begin
      fails++;
      $display("FAIL %s frame_err pulses: got %0d expected %0d", name, err_pulses - err_base, err_exp);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ir_in = 1'b1; bus.ack = 1'b0;
    wait_cyc(3);
    exp_ready = 1'b0; exp_cmd = 32'd0;
    check_outputs("reset", err_pulses, 0);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset frame_err: got %b expected 0", frame_err);
    end
    rst = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_nominal();
    int e0;
    e0 = err_pulses;
    send_frame(32'hFE010707, 1'b0);
    wait_cyc(3);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL nominal ready early: got %b expected 0", bus.ready);
    end
    wait_cyc(1);
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL nominal ready latency: got %b expected 1", bus.ready);
    end
    wait_cyc(10);
    e0 = e0 + model_frame(32'hFE010707) - 0;
    check_outputs("nominal", e0 - frame_ok(32'hFE010707) + 1, frame_ok(32'hFE010707) ? 0 : 1);
  endtask

  task automatic test_ack_block();
    int e0;
    bus.ack = 1'b1;
    if (exp_ready) exp_ready = 1'b0;
    wait_cyc(1);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL ack_drop ready: got %b expected 0", bus.ready);
    end
    wait_cyc(199);
    e0 = err_pulses;
    send_frame(32'h9F600707, 1'b0);
    wait_cyc(10);
    check_outputs("ack_blocked", e0, model_frame(32'h9F600707));
    bus.ack = 1'b0;
    wait_cyc(50);
    e0 = err_pulses;
    send_frame(32'h9F600707, 1'b0);
    wait_cyc(10);
    check_outputs("ack_resend", e0, model_frame(32'h9F600707));
  endtask

  task automatic test_leader_err();
    int e0;
    e0 = err_pulses;
    hold(1'b0, 300);
    ir_in = 1'b1;
    wait_cyc(40);
    check_outputs("leader_short", e0, 1);
  endtask

  task automatic test_timeout();
    int e0, t0, n;
    e0 = err_pulses;
    send_bits($urandom, 10, 1'b1);
    hold(1'b0, 56);
    ir_in = 1'b1;
    t0 = cyc;
    n = 0;
    while ((err_pulses == e0) && (n < 800)) begin
      wait_cyc(1);
      n++;
    end
    tests++;
    if ((cyc - t0 < TIMEOUT + 1) || (cyc - t0 > TIMEOUT + 10)) begin
      fails++;
      $display("FAIL timeout latency: got %0d clk expected %0d..%0d", cyc - t0, TIMEOUT + 1, TIMEOUT + 10);
    end
    wait_cyc(20);
    check_outputs("timeout", e0, 1);
  endtask

  task automatic test_reset_midframe();
    int e0;
    send_bits($urandom, 21, 1'b1);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    exp_ready = 1'b0; exp_cmd = 32'd0;
    e0 = err_pulses;
    check_outputs("midframe_reset", e0, 0);
    wait_cyc(30);
    e0 = err_pulses;
    send_frame(32'h97680707, 1'b0);
    wait_cyc(10);
    check_outputs("after_reset", e0, model_frame(32'h97680707));
  endtask

  task automatic test_invert();
    int e0;
    bus.ack = 1'b1;
    if (exp_ready) exp_ready = 1'b0;
    wait_cyc(2);
    bus.ack = 1'b0;
    wait_cyc(5);
    e0 = err_pulses;
    send_frame(32'hFF010707, 1'b0);
    wait_cyc(10);
    check_outputs("invert_check", e0, model_frame(32'hFF010707));
  endtask

  task automatic test_random();
    int e0;
    logic [31:0] d;
    logic a;
    for (int k = 0; k < 2; k++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[31:24] = ~d[23:16];
      a = 1'($urandom_range(0, 1));
      bus.ack = a;
      if (a && exp_ready) exp_ready = 1'b0;
      wait_cyc(3);
      e0 = err_pulses;
      send_frame(d, 1'b1);
      wait_cyc(10);
      check_outputs("random_frame", e0, model_frame(d));
      bus.ack = 1'b0;
      wait_cyc(5);
    end
  endtask

  task automatic test_monitors();
    tests++;
    if (err_double !== 0) begin
      fails++;
      $display("FAIL frame_err width: got %0d multi-cycle pulses expected 0", err_double);
    end
    tests++;
    if (cmd_changed !== 0) begin
      fails++;
      $display("FAIL command stability: got %0d changes while ready expected 0", cmd_changed);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ack_block();
    test_leader_err();
    test_timeout();
    test_reset_midframe();
    test_invert();
    test_random();
    test_monitors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
